// File: rtl/wordcount_result_packer.sv
// Packs {key, count} records from the word-count core into full-width AXI-Stream beats.
// Optional trailer beat {beat_total, rec_total} enabled by defining WORDCOUNT_PACKER_TRAILER_EN.
module wordcount_result_packer #(
  parameter int C_DATA_WIDTH  = 512,
  parameter int C_KEY_WIDTH   = 32,
  parameter int C_COUNT_WIDTH = 32
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic                     s_rec_valid,
  output logic                     s_rec_ready,
  input  logic [C_KEY_WIDTH-1:0]   s_rec_key,
  input  logic [C_COUNT_WIDTH-1:0] s_rec_count,
  input  logic                     s_rec_last,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic [31:0]              rec_total,
  output logic [31:0]              beat_total
);

  localparam int REC_W  = C_KEY_WIDTH + C_COUNT_WIDTH;
  localparam int RPB    = C_DATA_WIDTH / REC_W;
  localparam int SLOT_W = (RPB > 1) ? $clog2(RPB) : 1;

`ifdef WORDCOUNT_PACKER_TRAILER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, TRAILER = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t                  state, state_next;
  logic [SLOT_W-1:0]       slot;
  logic                    last_seen;
  logic [C_DATA_WIDTH-1:0] acc;
  logic [C_DATA_WIDTH-1:0] acc_ins;
  logic                    rec_fire;
  logic                    out_fire;
  logic                    beat_fire;
  logic                    final_fire;
`ifdef WORDCOUNT_PACKER_TRAILER_EN
  logic [C_DATA_WIDTH-1:0] trailer;
`endif

  function automatic logic [C_DATA_WIDTH-1:0] pack_rec(
    input logic [C_DATA_WIDTH-1:0]  base,
    input logic [SLOT_W-1:0]        idx,
    input logic [C_KEY_WIDTH-1:0]   key,
    input logic [C_COUNT_WIDTH-1:0] count
  );
    logic [C_DATA_WIDTH-1:0] r;
    r = base;
    r[int'(idx)*REC_W +: REC_W] = {key, count};
    return r;
  endfunction

  // Records are refused once the final record is in, until the job retires.
  assign s_rec_ready = (state == FILL) && !last_seen && (!m_axis_tvalid || m_axis_tready);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  always_comb begin
    rec_fire   = s_rec_valid && s_rec_ready;
    out_fire   = m_axis_tvalid && m_axis_tready;
    beat_fire  = rec_fire && ((slot == SLOT_W'(RPB - 1)) || s_rec_last);
    acc_ins    = pack_rec(acc, slot, s_rec_key, s_rec_count);
    final_fire = (state == FILL) && last_seen && out_fire;
`ifdef WORDCOUNT_PACKER_TRAILER_EN
    trailer        = '0;
    trailer[31:0]  = rec_total;
    trailer[63:32] = beat_total;
`endif
    state_next = state;
    case (state)
      IDLE: if (start) state_next = FILL;
`ifdef WORDCOUNT_PACKER_TRAILER_EN
      FILL: if (final_fire) state_next = TRAILER;
      TRAILER: if (out_fire) state_next = DONE;
`else
      FILL: if (final_fire) state_next = DONE;
`endif
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state         <= IDLE;
      slot          <= '0;
      last_seen     <= 1'b0;
      rec_total     <= '0;
      beat_total    <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && start) begin
        slot       <= '0;
        last_seen  <= 1'b0;
        rec_total  <= '0;
        beat_total <= '0;
      end
      if (rec_fire) begin
        rec_total <= rec_total + 32'd1;
        if (beat_fire) begin
          slot       <= '0;
          beat_total <= beat_total + 32'd1;
          last_seen  <= s_rec_last;
        end else begin
          slot <= slot + SLOT_W'(1);
        end
      end
      // Output register: a completing beat may reload it on the same edge as a handshake.
      if (beat_fire) begin
        m_axis_tdata  <= acc_ins;
        m_axis_tvalid <= 1'b1;
`ifdef WORDCOUNT_PACKER_TRAILER_EN
        m_axis_tlast  <= 1'b0;
`else
        m_axis_tlast  <= s_rec_last;
`endif
      end
`ifdef WORDCOUNT_PACKER_TRAILER_EN
      else if (final_fire) begin
        m_axis_tdata  <= trailer;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= 1'b1;
      end
`endif
      else if (out_fire) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

  // Accumulator is cleared at job start, so it needs no reset.
  always_ff @(posedge ap_clk) begin
    if ((state == IDLE) && start) begin
      acc <= '0;
    end else if (beat_fire) begin
      acc <= '0;
    end else if (rec_fire) begin
      acc <= acc_ins;
    end
  end

endmodule

// File: tb/tb_wordcount_result_packer.sv
// Bench for wordcount_result_packer: reference beats built from record lists; honours WORDCOUNT_PACKER_TRAILER_EN.
module tb_wordcount_result_packer;
  localparam int DW  = 512;
  localparam int RW  = 64;
  localparam int RPB = DW / RW;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic          s_rec_valid = 1'b0;
  logic          s_rec_ready;
  logic [31:0]   s_rec_key = '0;
  logic [31:0]   s_rec_count = '0;
  logic          s_rec_last = 1'b0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic [31:0]   rec_total, beat_total;

  int checks = 0;
  int failures = 0;

  logic [31:0]   keys[$];
  logic [31:0]   cnts[$];
  logic [DW-1:0] exp_data[$];
  logic          exp_last[$];

  wordcount_result_packer dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .busy(busy), .done(done),
    .s_rec_valid(s_rec_valid), .s_rec_ready(s_rec_ready), .s_rec_key(s_rec_key),
    .s_rec_count(s_rec_count), .s_rec_last(s_rec_last),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .rec_total(rec_total), .beat_total(beat_total)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic make_records(input int n, input bit directed);
    keys.delete();
    cnts.delete();
    for (int i = 0; i < n; i++) begin
      keys.push_back(directed ? 32'(i) : $urandom);
      cnts.push_back(directed ? 32'(i + 100) : $urandom);
    end
  endtask

  // Record i lands in beat i/RPB, slot i%RPB; unused slots stay zero.
  task automatic build_model(input int n);
    int nb;
    logic [DW-1:0] d;
    exp_data.delete();
    exp_last.delete();
    nb = (n + RPB - 1) / RPB;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      for (int i = b * RPB; i < n && i < (b + 1) * RPB; i++)
        d[(i % RPB) * RW +: RW] = {keys[i], cnts[i]};
      exp_data.push_back(d);
`ifdef WORDCOUNT_PACKER_TRAILER_EN
      exp_last.push_back(1'b0);
`else
      exp_last.push_back(b == nb - 1);
`endif
    end
`ifdef WORDCOUNT_PACKER_TRAILER_EN
    d = '0;
    d[31:0]  = 32'(n);
    d[63:32] = 32'(nb);
    exp_data.push_back(d);
    exp_last.push_back(1'b1);
`endif
  endtask

  task automatic do_start();
    @(negedge ap_clk);
    start = 1'b1;
    #1;
    chk("busy_before_start", busy, 1'b0);
    @(negedge ap_clk);
    start = 1'b0;
    #1;
    chk("busy_after_start", busy, 1'b1);
    @(negedge ap_clk);
  endtask

  // mode 0: tready=1; mode 1: random tready and record gaps; mode 2: 10-cycle stall on first beat.
  task automatic run_job(input int n, input int mode, input int start_mid);
    int rec_idx = 0, cyc = 0, hs_last = -10, done_cyc = -1, stall_left = 0;
    bit stall_used = 0, prev_hold = 0, prev_rec_hs = 1;
    logic [DW-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    build_model(n);
    while (done_cyc < 0 && cyc < 3000) begin
      cyc++;
      case (mode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = ($urandom_range(0, 3) != 0);
        default: begin
          if (m_axis_tvalid && !stall_used) begin
            stall_used = 1;
            stall_left = 10;
          end
          m_axis_tready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
      endcase
      start = (cyc == start_mid);
      if (rec_idx < n) begin
        if (!s_rec_valid || prev_rec_hs)
          s_rec_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_rec_key   = keys[rec_idx];
        s_rec_count = cnts[rec_idx];
        s_rec_last  = (rec_idx == n - 1);
      end else begin
        s_rec_valid = 1'b0;
        s_rec_last  = 1'b0;
      end
      #1;
      if (prev_hold) begin
        chk("hold_tvalid", m_axis_tvalid, 1'b1);
        chk("hold_tdata", m_axis_tdata, prev_data);
        chk("hold_tlast", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && !m_axis_tready) chk("backpressure_ready", s_rec_ready, 1'b0);
      prev_hold = m_axis_tvalid && !m_axis_tready;
      prev_data = m_axis_tdata;
      prev_last = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_data.size() == 0) begin
          chk("extra_beat", 1'b1, 1'b0);
        end else begin
          chk("beat_data", m_axis_tdata, exp_data.pop_front());
          chk("beat_last", m_axis_tlast, exp_last.pop_front());
          if (m_axis_tlast) hs_last = cyc;
        end
      end
      if (done) done_cyc = cyc;
      prev_rec_hs = s_rec_valid && s_rec_ready;
      if (prev_rec_hs) rec_idx++;
      @(negedge ap_clk);
    end
    start = 1'b0;
    s_rec_valid = 1'b0;
    chk("done_seen", (done_cyc > 0), 1'b1);
    chk("done_timing", done_cyc, hs_last + 1);
    chk("beats_remaining", exp_data.size(), 0);
    chk("rec_total", rec_total, 32'(n));
    chk("beat_total", beat_total, 32'((n + RPB - 1) / RPB));
    #1;
    chk("done_one_cycle", done, 1'b0);
    chk("busy_after_done", busy, 1'b0);
  endtask

  initial begin
    #2;
    chk("rst_ready", s_rec_ready, 1'b0);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rec_total", rec_total, '0);
    chk("rst_beat_total", beat_total, '0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // One full beat, directed records.
    make_records(8, 1);
    do_start();
    run_job(8, 0, 0);

    // Nine records: second beat is partial.
    make_records(9, 1);
    do_start();
    run_job(9, 0, 0);

    // Output stall of 10 cycles.
    make_records(20, 0);
    do_start();
    run_job(20, 2, 0);

    // Random backpressure plus a start pulse mid-job.
    make_records(30, 0);
    do_start();
    run_job(30, 1, 4);

    // Exact multiple of a beat under random backpressure.
    make_records(16, 0);
    do_start();
    run_job(16, 1, 0);

    // Reset mid-job after 5 records.
    make_records(5, 0);
    do_start();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_rec_valid = 1'b1;
      s_rec_key   = keys[i];
      s_rec_count = cnts[i];
      s_rec_last  = 1'b0;
      @(negedge ap_clk);
    end
    s_rec_valid = 1'b0;
    #1;
    chk("pre_reset_rec_total", rec_total, 32'd5);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("abort_ready", s_rec_ready, 1'b0);
    chk("abort_tvalid", m_axis_tvalid, 1'b0);
    chk("abort_tdata", m_axis_tdata, '0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rec_total", rec_total, '0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      #1;
      chk("post_reset_no_beat", m_axis_tvalid, 1'b0);
    end
    make_records(9, 0);
    do_start();
    run_job(9, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
